uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser_if.sv | 28 ++
 rtl/uart_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Signal bundle between the UART byte receiver, the frame parser and the
// command-execution consumer of the released payload stream.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] out_cmd;
    logic [7:0] out_len;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] drop_cnt;

    modport master (
        output rx_data, rx_done, out_ready,
        input  out_data, out_valid, out_last, out_cmd, out_len,
        input  frame_err, err_code, busy, drop_cnt
    );

    modport slave (
        input  rx_data, rx_done, out_ready,
        output out_data, out_valid, out_last, out_cmd, out_len,
        output frame_err, err_code, busy, drop_cnt
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles 55 AA LEN CMD payload CHK frames from a UART byte stream, checks the
// XOR checksum and releases the buffered payload on a valid/ready stream.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 104160
) (
    input logic                clk,
    input logic                rst,
    uart_frame_parser_if.slave bus
);
    localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StSync2, StLen, StCmd, StPayload, StChk, StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  wr_idx_q, wr_idx_d;
    logic [7:0]  rd_idx_q, rd_idx_d;
    logic [7:0]  rd_next;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [7:0]  out_cmd_q, out_cmd_d;
    logic [7:0]  out_len_q, out_len_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        buf_we;
    logic [7:0]  buf_q [MAX_LEN];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cmd_d       = cmd_q;
        chk_d       = chk_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = '0;
        out_data_d  = out_data_q;
        out_cmd_d   = out_cmd_q;
        out_len_d   = out_len_q;
        drop_cnt_d  = drop_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;
        rd_next     = rd_idx_q + 8'd1;

        // A strobe in the expiry cycle takes the byte path below instead.
        if (state_q != StIdle && state_q != StDrain && !bus.rx_done) begin
            if (tmo_q == TmoLast) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd3;
                state_d     = StIdle;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        if (bus.rx_done) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_data == 8'h55) state_d = StSync2;
                end
                StSync2: begin
                    if (bus.rx_data == 8'hAA)      state_d = StLen;
                    else if (bus.rx_data != 8'h55) state_d = StIdle;
                end
                StLen: begin
                    if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > MAX_LEN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = StIdle;
                    end else begin
                        len_d    = bus.rx_data;
                        chk_d    = bus.rx_data;
                        wr_idx_d = 8'd0;
                        state_d  = StCmd;
                    end
                end
                StCmd: begin
                    cmd_d   = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = StPayload;
                end
                StPayload: begin
                    buf_we   = 1'b1;
                    chk_d    = chk_q ^ bus.rx_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q == len_q - 8'd1) state_d = StChk;
                end
                StChk: begin
                    if (bus.rx_data == chk_q) begin
                        out_cmd_d   = cmd_q;
                        out_len_d   = len_q;
                        out_valid_d = 1'b1;
                        out_data_d  = buf_q[0];
                        out_last_d  = (len_q == 8'd1);
                        rd_idx_d    = 8'd0;
                        state_d     = StDrain;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = StIdle;
                    end
                end
                StDrain: begin
                    if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                end
                default: state_d = StIdle;
            endcase
        end

        // Next byte is loaded on the handshake itself so ready-high streams without bubbles.
        if (state_q == StDrain && out_valid_q && bus.out_ready) begin
            if (rd_idx_q == out_len_q - 8'd1) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = StIdle;
            end else begin
                rd_idx_d   = rd_next;
                out_data_d = buf_q[rd_next[IdxW-1:0]];
                out_last_d = (rd_next == out_len_q - 8'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= 8'd0;
            cmd_q       <= 8'd0;
            chk_q       <= 8'd0;
            wr_idx_q    <= 8'd0;
            rd_idx_q    <= 8'd0;
            tmo_q       <= 32'd0;
            out_data_q  <= 8'd0;
            out_cmd_q   <= 8'd0;
            out_len_q   <= 8'd0;
            drop_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cmd_q       <= cmd_d;
            chk_q       <= chk_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_cmd_q   <= out_cmd_d;
            out_len_q   <= out_len_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_idx_q[IdxW-1:0]] <= bus.rx_data;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cmd   = out_cmd_q;
    assign bus.out_len   = out_len_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a frame table plus hand-written sequences
// for stalls, DRAIN overflow, back-to-back frames, timeout and mid-frame reset.
module tb_uart_frame_parser;
    localparam int unsigned TMO = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .MAX_LEN    (16),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string        name;
        logic [191:0] bytes;    // frame bytes, first byte most significant
        int           nbytes;
        int           exp_err;  // 0 = no error, else expected err_code
        logic [7:0]   exp_cmd;
        logic [127:0] pay;      // expected payload, first byte most significant
        int           exp_len;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_mis = 0;

    logic [7:0] got_data[$];
    logic       got_last[$];
    logic [7:0] got_cmd;
    logic [7:0] got_len;
    int         mon_errs;
    logic [1:0] mon_code;
    logic       stall_q = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    bit         toggle_ready = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        repeat (gap) step();
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        mon_errs = 0;
        mon_code = 2'd0;
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while (bus.busy && c < 200) begin
            step();
            c++;
        end
        check({nm, "/idle"}, bus.busy, 0);
        repeat (2) step();
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "/busy"}, bus.busy, 0);
        check({nm, "/out_valid"}, bus.out_valid, 0);
        check({nm, "/out_last"}, bus.out_last, 0);
        check({nm, "/frame_err"}, bus.frame_err, 0);
        check({nm, "/err_code"}, bus.err_code, 0);
        check({nm, "/out_cmd"}, bus.out_cmd, 0);
        check({nm, "/out_len"}, bus.out_len, 0);
        check({nm, "/out_data"}, bus.out_data, 0);
        check({nm, "/drop_cnt"}, bus.drop_cnt, 0);
    endtask

    // Sampled mid-cycle: records handshakes, error pulses, and hold-while-stalled.
    always @(negedge clk) begin
        if (bus.frame_err) begin
            mon_errs++;
            mon_code = bus.err_code;
        end
        if (stall_q && bus.out_valid) begin
            check("hold_data", bus.out_data, held_data);
            check("hold_last", bus.out_last, held_last);
        end
        stall_q   = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
        held_last = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            got_cmd = bus.out_cmd;
            got_len = bus.out_len;
        end
    end

    always @(posedge clk) begin
        if (toggle_ready) begin
            #1 bus.out_ready = ~bus.out_ready;
        end
    end

    task automatic run_vec(input vec_t v);
        clear_mon();
        bus.out_ready = 1'b1;
        for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[8*(v.nbytes-1-i) +: 8], 1);
        wait_idle(v.name);
        check({v.name, "/errs"}, mon_errs, (v.exp_err != 0) ? 1 : 0);
        if (v.exp_err != 0) check({v.name, "/err_code"}, mon_code, v.exp_err);
        check({v.name, "/nbytes"}, got_data.size(), v.exp_len);
        for (int i = 0; i < v.exp_len && i < got_data.size(); i++) begin
            check({v.name, "/data"}, got_data[i], v.pay[8*(v.exp_len-1-i) +: 8]);
            check({v.name, "/last"}, got_last[i], (i == v.exp_len - 1) ? 1 : 0);
        end
        if (v.exp_len != 0) begin
            check({v.name, "/cmd"}, got_cmd, v.exp_cmd);
            check({v.name, "/len"}, got_len, v.exp_len);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] p[16];
        logic [7:0] ck;
        int         k;

        vecs[0] = '{"basic",      192'h55AA0210010211,       7, 0, 8'h10, 128'h0102, 2};
        vecs[1] = '{"bad_chk",    192'h55AA0210010212,       7, 1, 8'h00, 128'h0,    0};
        vecs[2] = '{"len1",       192'h55AA01207F5E,         6, 0, 8'h20, 128'h7F,   1};
        vecs[3] = '{"len0",       192'h55AA00,               3, 2, 8'h00, 128'h0,    0};
        vecs[4] = '{"len17",      192'h55AA11,               3, 2, 8'h00, 128'h0,    0};
        vecs[5] = '{"after_len",  192'h55AA0130AB9A,         6, 0, 8'h30, 128'hAB,   1};
        vecs[6] = '{"sync_noise", 192'h5555AA01050501,       7, 0, 8'h05, 128'h05,   1};
        vecs[7] = '{"garbage",    192'h12553455AA0240DEAD31, 10, 0, 8'h40, 128'hDEAD, 2};

        rst = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.out_ready = 1'b1;
        clear_mon();
        repeat (3) step();
        check_reset_vals("por");
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Full-length frame drained with out_ready toggling; 3 bytes land during DRAIN.
        clear_mon();
        ck = 8'h10 ^ 8'h5A;
        for (int i = 0; i < 16; i++) begin
            p[i] = 8'(i * 7 + 3);
            ck   = ck ^ p[i];
        end
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h10, 0);
        send_byte(8'h5A, 0);
        for (int i = 0; i < 16; i++) send_byte(p[i], 0);
        send_byte(ck, 0);
        toggle_ready = 1'b1;
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        wait_idle("max_len");
        toggle_ready = 1'b0;
        step();
        bus.out_ready = 1'b1;
        check("max_len/errs", mon_errs, 0);
        check("max_len/nbytes", got_data.size(), 16);
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            check("max_len/data", got_data[i], p[i]);
            check("max_len/last", got_last[i], (i == 15) ? 1 : 0);
        end
        check("max_len/cmd", got_cmd, 8'h5A);
        check("max_len/len", got_len, 16);
        check("max_len/drop_cnt", bus.drop_cnt, 3);

        // Strobe on the last-handshake cycle is dropped; the next cycle parses from IDLE.
        clear_mon();
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h7F, 0);
        send_byte(8'h5E, 0);
        send_byte(8'h55, 0);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h7F, 0);
        send_byte(8'h5E, 0);
        wait_idle("b2b");
        check("b2b/errs", mon_errs, 0);
        check("b2b/drop_cnt", bus.drop_cnt, 4);
        check("b2b/nbytes", got_data.size(), 2);
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            check("b2b/data", got_data[i], 8'h7F);
            check("b2b/last", got_last[i], 1);
        end

        // Timeout: strobe in cycle 0, counter expires in cycle TMO, pulse seen in TMO+1.
        clear_mon();
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h03, 0);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        k = 1;
        while (!bus.frame_err && k < TMO + 20) begin
            step();
            k++;
        end
        check("tmo/cycle", k, TMO + 1);
        check("tmo/err_code", bus.err_code, 3);
        step();
        check("tmo/pulse", bus.frame_err, 0);
        check("tmo/busy", bus.busy, 0);

        // Byte arriving exactly in the expiry cycle wins; frame completes normally.
        clear_mon();
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h03, 0);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        repeat (TMO - 1) step();
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h13, 0);
        wait_idle("tmo_edge");
        check("tmo_edge/errs", mon_errs, 0);
        check("tmo_edge/nbytes", got_data.size(), 3);
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            check("tmo_edge/data", got_data[i], i + 1);
        end
        check("tmo_edge/cmd", got_cmd, 8'h10);

        // Reset mid-PAYLOAD abandons the frame silently.
        clear_mon();
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h03, 1);
        send_byte(8'h10, 1);
        send_byte(8'h01, 1);
        check("mid/busy", bus.busy, 1);
        rst = 1'b1;
        step();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        step();
        check("mid_rst/errs", mon_errs, 0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
